// File: rtl/nor_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nor_reduce_pipe
// Brief    : Pipelined FANIN-limited OR/NOR reduction of N_IN lanes with a
//            valid/ready handshake. Optional done_count output is enabled by
//            defining NOR_REDUCE_PIPE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nor_reduce_pipe #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int FANIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  op_inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_zero
`ifdef NOR_REDUCE_PIPE_CNT_EN
  ,
  output logic [15:0]           done_count
`endif
);

  function automatic int calc_stages();
    int n;
    int s;
    n = N_IN;
    s = 0;
    while (n > 1 && FANIN >= 2) begin
      n = (n + FANIN - 1) / FANIN;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction

  localparam int S    = calc_stages();
  localparam int NGRP = (FANIN < 2) ? N_IN : (N_IN + FANIN - 1) / FANIN;

  if (N_IN < 1 || FANIN < 2) begin : g_bad_param
    $error("nor_reduce_pipe: requires N_IN >= 1 and FANIN >= 2");
  end

  logic                  advance;
  logic [N_IN*WIDTH-1:0] lvl     [S];
  logic                  lvl_vld [S];
  logic                  lvl_inv [S];

  assign advance    = ~out_valid | out_ready;
  assign in_ready   = advance;
  assign lvl[0]     = in_data;
  assign lvl_vld[0] = in_valid;
  assign lvl_inv[0] = op_inv;

  // Intermediate levels keep the full lane width; lanes past the live
  // partial count are zero, so they are harmless in the next level's groups.
  for (genvar s = 0; s < S - 1; s++) begin : g_mid
    logic [N_IN*WIDTH-1:0] data_d;
    logic [N_IN*WIDTH-1:0] data_q;
    logic                  vld_q;
    logic                  inv_q;

    for (genvar g = 0; g < N_IN; g++) begin : g_lane
      if (g < NGRP) begin : g_grp
        logic [WIDTH-1:0] part [FANIN+1];
        assign part[0] = '0;
        for (genvar k = 0; k < FANIN; k++) begin : g_term
          if (g * FANIN + k < N_IN) begin : g_use
            assign part[k+1] = part[k] | lvl[s][(g*FANIN+k)*WIDTH +: WIDTH];
          end else begin : g_skip
            assign part[k+1] = part[k];
          end
        end
        assign data_d[g*WIDTH +: WIDTH] = part[FANIN];
      end else begin : g_zero
        assign data_d[g*WIDTH +: WIDTH] = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= lvl_vld[s];
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        data_q <= data_d;
        inv_q  <= lvl_inv[s];
      end
    end

    assign lvl[s+1]     = data_q;
    assign lvl_vld[s+1] = vld_q;
    assign lvl_inv[s+1] = inv_q;
  end

  // Final level folds every remaining lane and applies the inversion.
  logic [WIDTH-1:0] fin_part [N_IN+1];
  logic [WIDTH-1:0] fin_d;
  logic             zero_d;

  assign fin_part[0] = '0;
  for (genvar i = 0; i < N_IN; i++) begin : g_fin
    assign fin_part[i+1] = fin_part[i] | lvl[S-1][i*WIDTH +: WIDTH];
  end

  assign fin_d  = lvl_inv[S-1] ? ~fin_part[N_IN] : fin_part[N_IN];
  assign zero_d = (fin_d == '0);

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else if (advance) begin
      out_valid_q <= lvl_vld[S-1];
      out_data_q  <= fin_d;
      out_zero_q  <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

`ifdef NOR_REDUCE_PIPE_CNT_EN
  logic [15:0] done_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_count_q <= '0;
    end else if (out_valid_q && out_ready) begin
      done_count_q <= done_count_q + 16'd1;
    end
  end

  assign done_count = done_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nor_reduce_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_nor_reduce_pipe
// Brief    : Self-checking bench for nor_reduce_pipe (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nor_reduce_pipe;
  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N*W-1:0] in_data = '0;
  logic         op_inv = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_zero;
`ifdef NOR_REDUCE_PIPE_CNT_EN
  logic [15:0]  done_count;
  logic [15:0]  exp_cnt = '0;
`endif

  always #5 clk = ~clk;

  nor_reduce_pipe #(.WIDTH(W), .N_IN(N), .FANIN(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_inv    (op_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef NOR_REDUCE_PIPE_CNT_EN
    .done_count(done_count),
`endif
    .out_zero  (out_zero)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [W-1:0] exp_q [$];
  logic         ov_s, oz_s, ir_s;
  logic [W-1:0] od_s;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: OR of all lanes, inverted when NOR is selected.
  function automatic logic [W-1:0] ref_model(input logic [N*W-1:0] d, input bit inv);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc | d[k*W +: W];
    return inv ? ~acc : acc;
  endfunction

  // One clock: drive at negedge, observe, and score the transfers that the
  // following rising edge will perform.
  task automatic cyc(input bit v, input logic [N*W-1:0] d, input bit inv,
                     input bit ordy, input bit r);
    logic [W-1:0] e;
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; op_inv = inv; out_ready = ordy;
    #1;
    ov_s = out_valid; od_s = out_data; oz_s = out_zero; ir_s = in_ready;
    if (r) begin
      exp_q.delete();
`ifdef NOR_REDUCE_PIPE_CNT_EN
      exp_cnt = '0;
`endif
    end else begin
      if (ov_s && ordy) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {31'b0, ov_s}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", {24'b0, od_s}, {24'b0, e});
          check_eq("out_zero", {31'b0, oz_s}, {31'b0, (e == '0)});
          pops++;
`ifdef NOR_REDUCE_PIPE_CNT_EN
          exp_cnt = exp_cnt + 16'd1;
`endif
        end
      end
      if (v && ir_s) exp_q.push_back(ref_model(d, inv));
    end
  endtask

  task automatic lat_test(input logic [N*W-1:0] d, input bit inv, input logic [W-1:0] exp);
    int n;
    cyc(1'b1, d, inv, 1'b1, 1'b0);
    n = 0;
    do begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n++;
    end while (!ov_s && n < 10);
    check_eq("latency", n, S);
    check_eq("lat_data", {24'b0, od_s}, {24'b0, exp});
  endtask

  function automatic logic [N*W-1:0] rand_set();
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0:       d[k*W +: W] = '0;
        1:       d[k*W +: W] = '1;
        default: d[k*W +: W] = W'($urandom);
      endcase
    end
    return d;
  endfunction

  initial begin
    logic [N*W-1:0] bp_vals [4];
    int idx, stall_left, p0, t;

    // Reset
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_ready_during", {31'b0, ir_s}, 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_valid", {31'b0, ov_s}, 32'd0);
    check_eq("rst_data", {24'b0, od_s}, 32'd0);
    check_eq("rst_zero", {31'b0, oz_s}, 32'd0);
    check_eq("rst_ready", {31'b0, ir_s}, 32'd1);

    // OR / NOR selection and extremes
    lat_test({8'h08, 8'h04, 8'h02, 8'h01}, 1'b1, 8'hF0);
    lat_test({8'h08, 8'h04, 8'h02, 8'h01}, 1'b0, 8'h0F);
    lat_test('0, 1'b1, 8'hFF);
    lat_test('1, 1'b1, 8'h00);
    check_eq("zero_flag_ff", {31'b0, oz_s}, 32'd1);
`ifdef NOR_REDUCE_PIPE_CNT_EN
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_after4", {16'b0, done_count}, 32'd4);
`endif

    // Backpressure: 4 back-to-back sets, 3-cycle stall after first result
    bp_vals[0] = {8'h11, 8'h00, 8'h00, 8'h00};
    bp_vals[1] = {8'h00, 8'h22, 8'h00, 8'h40};
    bp_vals[2] = {8'h00, 8'h00, 8'h80, 8'h00};
    bp_vals[3] = {8'h03, 8'h00, 8'h00, 8'h0C};
    idx = 0; stall_left = -1; p0 = pops;
    for (t = 0; t < 40; t++) begin
      cyc(idx < 4, (idx < 4) ? bp_vals[idx] : '0, 1'b1, !(stall_left > 0), 1'b0);
      if (idx < 4 && ir_s) idx++;
      if (stall_left > 0) begin
        check_eq("stall_ready", {31'b0, ir_s}, 32'd0);
        check_eq("stall_valid", {31'b0, ov_s}, 32'd1);
        if (exp_q.size() > 0) check_eq("stall_data", {24'b0, od_s}, {24'b0, exp_q[0]});
        stall_left--;
      end else if (stall_left < 0 && ov_s) begin
        stall_left = 3;
      end
      if (pops - p0 == 4 && exp_q.size() == 0) break;
    end
    check_eq("bp_count", pops - p0, 4);

    // Reset with two sets in flight
    cyc(1'b1, {8'h01, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, {8'h00, 8'h00, 8'h00, 8'h02}, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check_eq("flush_valid", {31'b0, ov_s}, 32'd0);
    end

`ifdef NOR_REDUCE_PIPE_CNT_EN
    for (int i = 0; i < 3; i++) lat_test('0, 1'b0, 8'h00);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt3", {16'b0, done_count}, 32'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rand_set(), 1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    t = 0;
    while ((exp_q.size() != 0 || ov_s) && t < 50) begin
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      t++;
    end
    check_eq("drain_empty", exp_q.size(), 0);

`ifdef NOR_REDUCE_PIPE_CNT_EN
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_model", {16'b0, done_count}, {16'b0, exp_cnt});
    t = 0;
    while (exp_cnt != 16'hFFFE && t < 70000) begin
      cyc(1'b1, rand_set(), 1'b0, 1'b1, 1'b0);
      t++;
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_fffe", {16'b0, done_count}, 32'h0000FFFE);
    t = 0;
    while (exp_cnt != 16'h0000 && t < 20) begin
      cyc(1'b1, rand_set(), 1'b0, 1'b1, 1'b0);
      t++;
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("cnt_wrap", {16'b0, done_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
